instruction_buffer: RTL and testbench
=====================================

Name: instruction_buffer

Overview:
- N-wide circular FIFO between Fetch and Dispatch.
- Enqueues up to N fetched instructions per cycle and presents the oldest N to Dispatch with a valid count.
- Dequeues exactly the num_dispatched instructions that Dispatch accepted.
- Flushed wholesale on branch mispredict restore; Fetch is throttled through a registered free-spot count.

Parameters:
- N, 3, superscalar width (same value as the global `N).
- IB_SZ, 16, buffer depth in instructions; must be a power of 2 and >= N.
- CNT_BITS, $clog2(IB_SZ+1), occupancy counter width.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- fetch_entries  input  FETCH_ENTRY[N]  fetched instructions, oldest at index 0
- num_fetched  input  NUM_SCALAR_BITS  count of valid fetch_entries (0..N), low indices valid
- ib_spots  output  NUM_SCALAR_BITS  min(IB_SZ - count, N); upper limit on num_fetched this cycle
- instruction_packets  output  FETCH_ENTRY[N]  oldest N entries, head at index 0
- instructions_valid  output  NUM_SCALAR_BITS  min(count, N)
- num_dispatched  input  NUM_SCALAR_BITS  entries Dispatch consumed this cycle (<= instructions_valid)
- restore_valid  input  1  mispredict recovery; flush entire buffer
- ib_count  output  CNT_BITS  current occupancy (debug/SVA)

Behaviour:
State
- head, tail: $clog2(IB_SZ) bits each.
- count: CNT_BITS.
- entries: FETCH_ENTRY[IB_SZ].

Outputs (combinational from registered state only)
- No same-cycle fetch-to-dispatch bypass.
- instruction_packets[i] = entries[(head+i) mod IB_SZ].
- Lanes i >= instructions_valid are don't-care (drive '0 preferred).
- ib_spots counts no credit for same-cycle dispatch.

Reset (synchronous, takes priority over everything)
- head=tail=count=0.
- Outputs then: instructions_valid=0, ib_spots=N, ib_count=0.
- Entry contents need not be cleared.
- Reset mid-operation discards all contents the next cycle.

Flush
- restore_valid=1, reset=0: next cycle head=tail=count=0.
- Same-cycle num_fetched and num_dispatched are ignored.

Normal cycle
- accepted = min(num_fetched, ib_spots).
  - num_fetched > ib_spots is a protocol violation; excess lanes are dropped and never written.
- Write fetch_entries[i] to entries[(tail+i) mod IB_SZ] for i < accepted.
- tail += accepted (mod IB_SZ).
- head += num_dispatched (mod IB_SZ).
- count <= count + accepted - num_dispatched, computed at CNT_BITS+1 width.
- num_dispatched > instructions_valid is a protocol violation (assert). RTL clamps it to instructions_valid so count never underflows.

Boundaries
- Full (count=IB_SZ): ib_spots=0, all fetch dropped.
- Empty: instructions_valid=0, any num_dispatched is clamped to 0.
- Simultaneous fetch and dispatch when full: dispatch frees slots only next cycle, so fetch is still refused this cycle.
- Pointer wrap is natural modulo; a group may straddle index IB_SZ-1 -> 0.
- Order is strictly FIFO: instruction_packets[0] is always the oldest surviving entry.

Invariant
- count == (tail - head) mod IB_SZ, except when count == IB_SZ (then head == tail).

Decomposition:
- In sys_defs.svh: FETCH_ENTRY typedef (inst, PC, NPC, pred_taken, valid), IB_SZ and IB_CNT_BITS constants, NUM_SCALAR_BITS.
- Single flat module; no sub-module needed.
- Companion instruction_buffer_sva checks:
  - the count invariant;
  - instructions_valid == min(count, N);
  - FIFO ordering via a scoreboard queue;
  - both protocol-violation conditions.

Test Plan:
- Reset -> instructions_valid=0, ib_spots=3, ib_count=0. Fetch 3 then dispatch 0 -> next cycle instructions_valid=3, PCs 0x0,0x4,0x8 in order.
- Fill: fetch 3/cycle with no dispatch for 5 cycles -> ib_count=15, ib_spots=1. Fetch 3 -> only PC of lane 0 accepted, ib_count=16, ib_spots=0. Next fetch dropped, count stays 16.
- Steady state at count 3: fetch 3 + dispatch 3 each cycle for 10 cycles -> count stays 3, head wraps past 15->0, packets remain in PC order with no duplicates or skips.
- Partial dispatch: count=5, dispatch 2 -> next cycle packet[0] is former entry 3, instructions_valid=3, count=3.
- Flush: count=9, restore_valid with fetch 3 and dispatch 2 same cycle -> next cycle count=0, instructions_valid=0, ib_spots=3. Subsequent fetch appears at packet[0].
- Reset asserted mid-stream at count=12 with concurrent fetch -> next cycle count=0. Post-reset fetch of PC 0x100 is output at lane 0.

Source files
------------

// File: rtl/instruction_buffer_pkg.sv
// Shared types and sizing for the fetch-to-dispatch instruction buffer.
package instruction_buffer_pkg;

  localparam int N               = 3;
  localparam int IB_SZ           = 16;
  localparam int CNT_BITS        = $clog2(IB_SZ + 1);
  localparam int PTR_BITS        = $clog2(IB_SZ);
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_taken;
    logic        valid;
  } fetch_entry_t;

  // Clamp an occupancy-sized quantity to the superscalar width.
  function automatic logic [NUM_SCALAR_BITS-1:0] clamp_to_width(input logic [CNT_BITS:0] value);
    return (value > (CNT_BITS + 1)'(N)) ? NUM_SCALAR_BITS'(N) : value[NUM_SCALAR_BITS-1:0];
  endfunction

endpackage

// File: rtl/instruction_buffer.sv
// N-wide circular FIFO between Fetch and Dispatch; outputs depend only on
// registered state, so fetched instructions become visible one cycle later.
module instruction_buffer
  import instruction_buffer_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  fetch_entry_t [N-1:0]                 fetch_entries_i,
  input  logic         [NUM_SCALAR_BITS-1:0]   num_fetched_i,
  output logic         [NUM_SCALAR_BITS-1:0]   ib_spots_o,
  output fetch_entry_t [N-1:0]                 instruction_packets_o,
  output logic         [NUM_SCALAR_BITS-1:0]   instructions_valid_o,
  input  logic         [NUM_SCALAR_BITS-1:0]   num_dispatched_i,
  input  logic                                 restore_valid_i,
  output logic         [CNT_BITS-1:0]          ib_count_o
);

  logic [PTR_BITS-1:0]        head_q, head_d;
  logic [PTR_BITS-1:0]        tail_q, tail_d;
  logic [CNT_BITS-1:0]        count_q, count_d;
  fetch_entry_t               entries_q [IB_SZ];

  logic [NUM_SCALAR_BITS-1:0] accepted;
  logic [NUM_SCALAR_BITS-1:0] dispatched;

  // Free-spot credit ignores same-cycle dispatch, so a full buffer refuses
  // fetch even while Dispatch is draining it.
  always_comb begin
    instructions_valid_o = clamp_to_width({1'b0, count_q});
    ib_spots_o           = clamp_to_width((CNT_BITS + 1)'(IB_SZ) - {1'b0, count_q});
    accepted             = (num_fetched_i > ib_spots_o) ? ib_spots_o : num_fetched_i;
    dispatched           = (num_dispatched_i > instructions_valid_o) ? instructions_valid_o
                                                                     : num_dispatched_i;
    ib_count_o           = count_q;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      instruction_packets_o[i] = '0;
      if (NUM_SCALAR_BITS'(i) < instructions_valid_o) begin
        instruction_packets_o[i] = entries_q[head_q + PTR_BITS'(i)];
      end
    end
  end

  // Reset and flush both collapse the pointers; clamped counts keep the
  // occupancy from ever over- or underflowing.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset || restore_valid_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_BITS'(dispatched);
      tail_d  = tail_q + PTR_BITS'(accepted);
      count_d = count_q + CNT_BITS'(accepted) - CNT_BITS'(dispatched);
    end
  end

  // NOTE: reset is synchronous and already folded into the _d values, so this block is a plain register with non-blocking updates.
  always_ff @(posedge clock) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // NOTE: the entry storage is deliberately not reset; stale data is unreachable once count is zero.
  always_ff @(posedge clock) begin
    if (!reset && !restore_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if (NUM_SCALAR_BITS'(i) < accepted) begin
          entries_q[tail_q + PTR_BITS'(i)] <= fetch_entries_i[i];
        end
      end
    end
  end

  assert property (@(posedge clock) disable iff (reset)
    (count_q == CNT_BITS'(IB_SZ)) ? (head_q == tail_q)
                                  : ({1'b0, PTR_BITS'(tail_q - head_q)} == count_q));

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer: a queue model tracks the expected
// contents and a negedge process compares every visible output against it.
module tb_instruction_buffer;
  import instruction_buffer_pkg::*;

  logic                                clock;
  logic                                reset;
  fetch_entry_t [N-1:0]                fetch_entries;
  logic         [NUM_SCALAR_BITS-1:0]  num_fetched;
  logic         [NUM_SCALAR_BITS-1:0]  ib_spots;
  fetch_entry_t [N-1:0]                instruction_packets;
  logic         [NUM_SCALAR_BITS-1:0]  instructions_valid;
  logic         [NUM_SCALAR_BITS-1:0]  num_dispatched;
  logic                                restore_valid;
  logic         [CNT_BITS-1:0]         ib_count;

  instruction_buffer dut (
    .clock                 (clock),
    .reset                 (reset),
    .fetch_entries_i       (fetch_entries),
    .num_fetched_i         (num_fetched),
    .ib_spots_o            (ib_spots),
    .instruction_packets_o (instruction_packets),
    .instructions_valid_o  (instructions_valid),
    .num_dispatched_i      (num_dispatched),
    .restore_valid_i       (restore_valid),
    .ib_count_o            (ib_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int           total;
  int           bad;
  bit           model_on;
  fetch_entry_t model_q[$];
  int           last_acc;
  logic [31:0]  next_pc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.inst       = 32'hA500_0000 ^ pc;
    e.pc         = pc;
    e.npc        = pc + 32'd4;
    e.pred_taken = pc[2];
    e.valid      = 1'b1;
    return e;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model-vs-DUT comparison on every cycle once the first reset has landed.
  always @(negedge clock) begin
    int sz;
    int vexp;
    if (model_on) begin
      sz   = model_q.size();
      vexp = imin(sz, N);
      check("ib_count", 128'(ib_count), 128'(sz));
      check("ib_spots", 128'(ib_spots), 128'(imin(IB_SZ - sz, N)));
      check("instructions_valid", 128'(instructions_valid), 128'(vexp));
      for (int i = 0; i < N; i++) begin
        if (i < vexp) check($sformatf("packet[%0d]", i), 128'(instruction_packets[i]), 128'(model_q[i]));
      end
    end
  end

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic cycle(input int nf, input logic [31:0] pc0, input int nd, input bit rv, input bit rs);
    int sz;
    int acc;
    int ndis;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      fetch_entries[i] = (i < nf) ? mk(pc0 + 32'(4 * i)) : mk(32'hBAD0_0000 + 32'(4 * i));
    end
    num_fetched    = NUM_SCALAR_BITS'(nf);
    num_dispatched = NUM_SCALAR_BITS'(nd);
    restore_valid  = rv;
    reset          = rs;
    @(posedge clock);
    sz = model_q.size();
    if (rs || rv) begin
      model_q.delete();
      last_acc = 0;
    end else begin
      acc  = imin(nf, imin(IB_SZ - sz, N));
      ndis = imin(nd, imin(sz, N));
      repeat (ndis) void'(model_q.pop_front());
      for (int i = 0; i < acc; i++) model_q.push_back(fetch_entries[i]);
      last_acc = acc;
    end
    #1;
  endtask

  task automatic fetch(input int nf, input int nd);
    cycle(nf, next_pc, nd, 1'b0, 1'b0);
    next_pc = next_pc + 32'(4 * last_acc);
  endtask

  initial begin
    total = 0; bad = 0; model_on = 0; last_acc = 0; next_pc = 32'h0;
    reset = 1'b1; restore_valid = 1'b0; num_fetched = '0; num_dispatched = '0;
    fetch_entries = '0;

    cycle(0, 32'h0, 0, 1'b0, 1'b1);
    cycle(0, 32'h0, 0, 1'b0, 1'b1);
    model_on = 1;
    check("reset valid", 128'(instructions_valid), 128'd0);
    check("reset spots", 128'(ib_spots), 128'd3);
    check("reset count", 128'(ib_count), 128'd0);

    // First group appears in order one cycle later.
    fetch(3, 0);
    check("first valid", 128'(instructions_valid), 128'd3);
    check("first pc0", 128'(instruction_packets[0].pc), 128'h0);
    check("first pc1", 128'(instruction_packets[1].pc), 128'h4);
    check("first pc2", 128'(instruction_packets[2].pc), 128'h8);
    fetch(0, 3);

    // Fill to 15, then overflow by two lanes, then fetch against a full buffer.
    repeat (5) fetch(3, 0);
    check("fill count15", 128'(ib_count), 128'd15);
    check("fill spots1", 128'(ib_spots), 128'd1);
    fetch(3, 0);
    check("full count", 128'(ib_count), 128'd16);
    check("full spots", 128'(ib_spots), 128'd0);
    fetch(3, 0);
    check("dropped count", 128'(ib_count), 128'd16);
    fetch(3, 3);
    check("full fetch+disp count", 128'(ib_count), 128'd13);
    check("full fetch+disp pc0", 128'(instruction_packets[0].pc), 128'h18);

    // Drain to 3, then steady state across the pointer wrap.
    repeat (3) fetch(0, 3);
    fetch(0, 1);
    check("drained count", 128'(ib_count), 128'd3);
    check("drained pc0", 128'(instruction_packets[0].pc), 128'h40);
    repeat (10) fetch(3, 3);
    check("steady count", 128'(ib_count), 128'd3);
    check("steady pc0", 128'(instruction_packets[0].pc), 128'hB8);
    check("steady pc2", 128'(instruction_packets[2].pc), 128'hC0);

    // Partial dispatch from 5 entries.
    fetch(2, 0);
    fetch(0, 2);
    check("partial count", 128'(ib_count), 128'd3);
    check("partial valid", 128'(instructions_valid), 128'd3);
    check("partial pc0", 128'(instruction_packets[0].pc), 128'hC0);

    // Flush at 9 with concurrent fetch and dispatch.
    fetch(3, 0);
    fetch(3, 0);
    check("preflush count", 128'(ib_count), 128'd9);
    cycle(3, next_pc, 2, 1'b1, 1'b0);
    check("flush count", 128'(ib_count), 128'd0);
    check("flush valid", 128'(instructions_valid), 128'd0);
    check("flush spots", 128'(ib_spots), 128'd3);
    fetch(3, 0);
    check("postflush pc0", 128'(instruction_packets[0].pc), 128'hE4);
    fetch(0, 3);
    fetch(0, 2);
    check("empty clamp count", 128'(ib_count), 128'd0);

    // Reset mid-stream at 12 with a concurrent fetch.
    repeat (4) fetch(3, 0);
    check("prereset count", 128'(ib_count), 128'd12);
    cycle(3, next_pc, 0, 1'b0, 1'b1);
    check("midreset count", 128'(ib_count), 128'd0);
    next_pc = 32'h100;
    fetch(1, 0);
    check("postreset pc0", 128'(instruction_packets[0].pc), 128'h100);
    check("postreset valid", 128'(instructions_valid), 128'd1);

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
